// File: rtl/rx_check.sv
// Single-byte receive checker: arms on start, waits for a UART byte or timeout, compares against exp_byte.
// Optional RX_CHECK_SEQ_EN makes exp_byte advance after every match (incrementing expected sequence).
module rx_check #(
    parameter logic [7:0]  EXP_BYTE = 8'd55,
    parameter logic [23:0] TIMEOUT  = 24'd50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clr_cnt,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       busy,
    output logic [7:0] rx_byte,
    output logic [7:0] exp_byte,
    output logic       match,
    output logic       mismatch,
    output logic       timeout,
    output logic [7:0] match_cnt,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

    state_t      state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [7:0]  exp_byte_q, exp_byte_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic        match_q, match_d;
    logic        mismatch_q, mismatch_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        rx_byte_d = rx_byte_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    timer_d = 24'd0;
                end
            end
            WAIT: begin
                timer_d = timer_q + 24'd1;
                // A byte arriving on the terminal-count cycle takes priority over the timeout.
                if (i_Rx_DV) begin
                    rx_byte_d = i_Rx_Byte;
                    state_d   = CHECK;
                end else if (timer_q == TIMEOUT - 24'd1) begin
                    timeout_d = 1'b1;
                    timer_d   = 24'd0;
                    state_d   = IDLE;
                end
            end
            CHECK: begin
                hit_d   = (rx_byte_q == exp_byte_q);
                miss_d  = (rx_byte_q != exp_byte_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Compare result is staged once more so the pulse lands two edges after the byte was sampled.
    always_comb begin
        match_d     = hit_q;
        mismatch_d  = miss_q;
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (clr_cnt) begin
            match_cnt_d = 8'd0;
            err_cnt_d   = 8'd0;
        end else begin
            if (hit_q && (match_cnt_q != 8'hFF)) begin
                match_cnt_d = match_cnt_q + 8'd1;
            end
            if ((miss_q || timeout_d) && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
`ifdef RX_CHECK_SEQ_EN
        exp_byte_d = hit_q ? (exp_byte_q + 8'd1) : exp_byte_q;
`else
        exp_byte_d = EXP_BYTE;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= 24'd0;
            rx_byte_q   <= 8'd0;
            exp_byte_q  <= EXP_BYTE;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            match_q     <= 1'b0;
            mismatch_q  <= 1'b0;
            timeout_q   <= 1'b0;
            match_cnt_q <= 8'd0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rx_byte_q   <= rx_byte_d;
            exp_byte_q  <= exp_byte_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            timeout_q   <= timeout_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign rx_byte   = rx_byte_q;
    assign exp_byte  = exp_byte_q;
    assign match     = match_q;
    assign mismatch  = mismatch_q;
    assign timeout   = timeout_q;
    assign match_cnt = match_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule
